// File: rtl/lpc_uart_pkg.sv
// Shared definitions for the LPC-to-UART transfer controller: TX FSM encoding,
// the value presented on an empty RX read, and default sizing.
package lpc_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_BUSY = 2'd1,
    TX_WAIT_DONE = 2'd2
  } tx_state_t;

  localparam logic [7:0] EMPTY_READ           = 8'hFF;
  localparam int         DEFAULT_FIFO_AW      = 2;
  localparam int         DEFAULT_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/lpc_uart_xfer_ctl_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
  import lpc_uart_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   wdata,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level,
  output logic [WIDTH-1:0]   head
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[FIFO_AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[FIFO_AW-1:0]] <= wdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/lpc_uart_xfer_ctl.sv
// Moves host bytes into the UART transmitter through a TX FIFO and buffers
// received bytes in an RX FIFO, with host-visible status and sticky overrun.
module lpc_uart_xfer_ctl
  import lpc_uart_pkg::*;
#(
  parameter int FIFO_AW      = DEFAULT_FIFO_AW,
  parameter int BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT
) (
  input  logic             lpc_clk,
  input  logic             lpc_rst,
  input  logic [7:0]       host_tx_data,
  input  logic             host_tx_valid,
  output logic             host_tx_full,
  output logic [FIFO_AW:0] host_tx_level,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_start,
  input  logic             uart_tx_busy,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic [7:0]       host_rx_data,
  output logic             host_rx_avail,
  input  logic             host_rx_pop,
  output logic             rx_overrun,
  input  logic             overrun_clr
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_t        state;
  logic [CW-1:0]    wait_cnt;
  logic             tx_valid_q;
  logic             rx_valid_q;
  logic             tx_edge;
  logic             rx_edge;
  logic             tx_push;
  logic             tx_pop;
  logic             tx_empty;
  logic [7:0]       tx_head;
  logic             rx_pop;
  logic             rx_full;
  logic             rx_empty;
  logic [FIFO_AW:0] rx_level;
  logic [7:0]       rx_head;

  assign tx_edge = host_tx_valid && !tx_valid_q;
  assign rx_edge = uart_rx_valid && !rx_valid_q;

  // Full is judged before this cycle's pop, so a write into a full FIFO is lost.
  assign tx_push = tx_edge && !host_tx_full;
  assign tx_pop  = (state == TX_IDLE) && !tx_empty && !uart_tx_busy;
  assign rx_pop  = host_rx_pop && !rx_empty;

  assign host_rx_avail = (rx_level != '0);
  assign host_rx_data  = rx_empty ? EMPTY_READ : rx_head;

  sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
    .clk   (lpc_clk),
    .rst   (lpc_rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (host_tx_data),
    .full  (host_tx_full),
    .empty (tx_empty),
    .level (host_tx_level),
    .head  (tx_head)
  );

  sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
    .clk   (lpc_clk),
    .rst   (lpc_rst),
    .push  (rx_edge),
    .pop   (rx_pop),
    .wdata (uart_rx_data),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level),
    .head  (rx_head)
  );

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      tx_valid_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_valid_q <= host_tx_valid;
      rx_valid_q <= uart_rx_valid;
      // A byte is lost only if no pop frees a slot in the same cycle.
      if (rx_edge && rx_full && !rx_pop) rx_overrun <= 1'b1;
      else if (overrun_clr)              rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      state         <= TX_IDLE;
      wait_cnt      <= '0;
      uart_tx_start <= 1'b0;
      uart_tx_data  <= 8'h00;
    end else begin
      uart_tx_start <= 1'b0;
      case (state)
        TX_IDLE: begin
          if (tx_pop) begin
            uart_tx_data  <= tx_head;
            uart_tx_start <= 1'b1;
            wait_cnt      <= '0;
            state         <= TX_WAIT_BUSY;
          end
        end
        TX_WAIT_BUSY: begin
          // A transmitter that never raises busy is assumed to have sent the byte.
          if (uart_tx_busy)                           state <= TX_WAIT_DONE;
          else if (wait_cnt == CW'(BUSY_TIMEOUT - 1)) state <= TX_IDLE;
          else                                        wait_cnt <= wait_cnt + 1'b1;
        end
        TX_WAIT_DONE: begin
          if (!uart_tx_busy) state <= TX_IDLE;
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_uart_xfer_ctl.sv
// Self-checking bench for lpc_uart_xfer_ctl: table-driven RX vectors, directed
// TX/reset sequences, and randomized traffic against queue-based models.
module tb_lpc_uart_xfer_ctl;

  localparam int AW      = 2;
  localparam int DEPTH   = 1 << AW;
  localparam int TIMEOUT = 16;

  logic          lpc_clk;
  logic          lpc_rst;
  logic [7:0]    host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_full;
  logic [AW:0]   host_tx_level;
  logic [7:0]    uart_tx_data;
  logic          uart_tx_start;
  logic          uart_tx_busy;
  logic [7:0]    uart_rx_data;
  logic          uart_rx_valid;
  logic [7:0]    host_rx_data;
  logic          host_rx_avail;
  logic          host_rx_pop;
  logic          rx_overrun;
  logic          overrun_clr;

  int checks = 0;
  int errors = 0;

  logic [7:0] sent_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_model[$];

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       pop;
    logic       clr;
    logic       exp_avail;
    logic [7:0] exp_data;
    logic       exp_ov;
  } rx_vec_t;

  rx_vec_t vecs[19];

  lpc_uart_xfer_ctl #(.FIFO_AW(AW), .BUSY_TIMEOUT(TIMEOUT)) dut (
    .lpc_clk       (lpc_clk),
    .lpc_rst       (lpc_rst),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_full  (host_tx_full),
    .host_tx_level (host_tx_level),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_start (uart_tx_start),
    .uart_tx_busy  (uart_tx_busy),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .host_rx_data  (host_rx_data),
    .host_rx_avail (host_rx_avail),
    .host_rx_pop   (host_rx_pop),
    .rx_overrun    (rx_overrun),
    .overrun_clr   (overrun_clr)
  );

  initial lpc_clk = 1'b0;
  always #5 lpc_clk = ~lpc_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge lpc_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input rx_vec_t v);
    uart_rx_valid = v.rx_valid;
    uart_rx_data  = v.rx_data;
    host_rx_pop   = v.pop;
    overrun_clr   = v.clr;
  endtask

  function automatic rx_vec_t mk(input logic v, input logic [7:0] d, input logic p, input logic c,
                                 input logic ea, input logic [7:0] ed, input logic eo);
    rx_vec_t r;
    r.rx_valid = v; r.rx_data = d; r.pop = p; r.clr = c;
    r.exp_avail = ea; r.exp_data = ed; r.exp_ov = eo;
    return r;
  endfunction

  task automatic pushTx(input logic [7:0] d);
    host_tx_data  = d;
    host_tx_valid = 1'b1;
    step();
    host_tx_valid = 1'b0;
    step();
  endtask

  task automatic pulseRx(input logic [7:0] d);
    uart_rx_data  = d;
    uart_rx_valid = 1'b1;
    step();
    uart_rx_valid = 1'b0;
    step();
  endtask

  // Behaves like a UART transmitter: busy for 3 cycles after each start pulse.
  task automatic drain(input int ncycles);
    int left;
    left = 0;
    uart_tx_busy = 1'b0;
    for (int i = 0; i < ncycles; i++) begin
      step();
      if (uart_tx_start) begin
        sent_q.push_back(uart_tx_data);
        uart_tx_busy = 1'b1;
        left = 3;
      end else if (left > 0) begin
        left--;
        if (left == 0) uart_tx_busy = 1'b0;
      end
    end
    uart_tx_busy = 1'b0;
  endtask

  initial begin
    int lat;
    int gap;
    int starts;
    bit found;
    logic [7:0] d;

    lpc_rst = 1'b1; host_tx_data = 8'h00; host_tx_valid = 1'b0; uart_tx_busy = 1'b0;
    uart_rx_data = 8'h00; uart_rx_valid = 1'b0; host_rx_pop = 1'b0; overrun_clr = 1'b0;
    step(); step();
    checkOutput("rst_tx_start", uart_tx_start, 0);
    checkOutput("rst_tx_data",  uart_tx_data, 8'h00);
    checkOutput("rst_tx_full",  host_tx_full, 0);
    checkOutput("rst_tx_level", host_tx_level, 0);
    checkOutput("rst_rx_avail", host_rx_avail, 0);
    checkOutput("rst_rx_data",  host_rx_data, 8'hFF);
    checkOutput("rst_overrun",  rx_overrun, 0);
    lpc_rst = 1'b0;
    step();

    // Single write with a responsive transmitter, host_tx_valid held high throughout.
    host_tx_data = 8'h41; host_tx_valid = 1'b1;
    lat = 0; found = 0;
    for (int i = 0; i < 10; i++) begin
      step(); lat++;
      if (uart_tx_start) begin found = 1; break; end
    end
    checkOutput("single_start_seen", found, 1);
    checkOutput("single_latency", lat, 2);
    checkOutput("single_data", uart_tx_data, 8'h41);
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("single_hold_data", uart_tx_data, 8'h41);
      checkOutput("single_no_restart", uart_tx_start, 0);
    end
    uart_tx_busy = 1'b0;
    starts = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (uart_tx_start) starts++;
    end
    checkOutput("held_valid_one_push", starts, 0);
    checkOutput("single_level_after", host_tx_level, 0);
    host_tx_valid = 1'b0;
    step();

    // TX fill with busy held high: fifth byte dropped.
    uart_tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) pushTx(8'h10 + 8'(i));
    checkOutput("fill_level", host_tx_level, 4);
    checkOutput("fill_full", host_tx_full, 1);
    sent_q.delete();
    drain(80);
    checkOutput("fill_sent_count", sent_q.size(), 4);
    for (int i = 0; i < 4 && i < sent_q.size(); i++)
      checkOutput("fill_sent_order", sent_q[i], 8'h10 + 8'(i));

    // Busy timeout: transmitter never answers.
    uart_tx_busy = 1'b1;
    pushTx(8'h55);
    pushTx(8'h66);
    uart_tx_busy = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (uart_tx_start) begin found = 1; break; end
    end
    checkOutput("timeout_first_start", found, 1);
    checkOutput("timeout_first_data", uart_tx_data, 8'h55);
    gap = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      step(); gap++;
      if (uart_tx_start) begin found = 1; break; end
    end
    checkOutput("timeout_second_start", found, 1);
    checkOutput("timeout_gap", gap, TIMEOUT + 1);
    checkOutput("timeout_second_data", uart_tx_data, 8'h66);
    for (int i = 0; i < 25; i++) step();

    // Randomized TX bursts against a byte queue.
    for (int it = 0; it < 3; it++) begin
      uart_tx_busy = 1'b1;
      exp_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 7)); k++) begin
        d = 8'($urandom);
        pushTx(d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        checkOutput("rand_tx_level", host_tx_level, exp_q.size());
      end
      checkOutput("rand_tx_full", host_tx_full, exp_q.size() == DEPTH);
      sent_q.delete();
      drain(100);
      checkOutput("rand_tx_count", sent_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
        checkOutput("rand_tx_byte", sent_q[i], exp_q[i]);
    end

    // Reset with bytes queued and an RX byte pending.
    uart_tx_busy = 1'b1;
    pushTx(8'h01); pushTx(8'h02); pushTx(8'h03);
    pulseRx(8'h77);
    checkOutput("prerst_level", host_tx_level, 3);
    lpc_rst = 1'b1; uart_tx_busy = 1'b0;
    step();
    checkOutput("inrst_start1", uart_tx_start, 0);
    step();
    checkOutput("inrst_start2", uart_tx_start, 0);
    checkOutput("inrst_level", host_tx_level, 0);
    checkOutput("inrst_full", host_tx_full, 0);
    checkOutput("inrst_tx_data", uart_tx_data, 8'h00);
    checkOutput("inrst_rx_avail", host_rx_avail, 0);
    checkOutput("inrst_rx_data", host_rx_data, 8'hFF);
    checkOutput("inrst_overrun", rx_overrun, 0);
    lpc_rst = 1'b0;
    starts = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (uart_tx_start) starts++;
    end
    checkOutput("postrst_no_start", starts, 0);

    // RX overrun and edge-detect table.
    vecs[0]  = mk(1, 8'hA0, 0, 0, 1, 8'hA0, 0);
    vecs[1]  = mk(0, 8'h00, 0, 0, 1, 8'hA0, 0);
    vecs[2]  = mk(1, 8'hA1, 0, 0, 1, 8'hA0, 0);
    vecs[3]  = mk(0, 8'h00, 0, 0, 1, 8'hA0, 0);
    vecs[4]  = mk(1, 8'hA2, 0, 0, 1, 8'hA0, 0);
    vecs[5]  = mk(0, 8'h00, 0, 0, 1, 8'hA0, 0);
    vecs[6]  = mk(1, 8'hA3, 0, 0, 1, 8'hA0, 0);
    vecs[7]  = mk(0, 8'h00, 0, 0, 1, 8'hA0, 0);
    vecs[8]  = mk(1, 8'hA4, 0, 0, 1, 8'hA0, 1);
    vecs[9]  = mk(0, 8'h00, 0, 0, 1, 8'hA0, 1);
    vecs[10] = mk(0, 8'h00, 1, 0, 1, 8'hA1, 1);
    vecs[11] = mk(0, 8'h00, 1, 0, 1, 8'hA2, 1);
    vecs[12] = mk(0, 8'h00, 1, 0, 1, 8'hA3, 1);
    vecs[13] = mk(0, 8'h00, 1, 0, 0, 8'hFF, 1);
    vecs[14] = mk(0, 8'h00, 1, 0, 0, 8'hFF, 1);
    vecs[15] = mk(0, 8'h00, 0, 1, 0, 8'hFF, 0);
    vecs[16] = mk(1, 8'hB0, 0, 0, 1, 8'hB0, 0);
    vecs[17] = mk(1, 8'hB1, 1, 0, 0, 8'hFF, 0);
    vecs[18] = mk(0, 8'h00, 0, 0, 0, 8'hFF, 0);
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("vec%0d_avail", i), host_rx_avail, vecs[i].exp_avail);
      checkOutput($sformatf("vec%0d_data", i), host_rx_data, vecs[i].exp_data);
      checkOutput($sformatf("vec%0d_overrun", i), rx_overrun, vecs[i].exp_ov);
    end
    host_rx_pop = 1'b0; overrun_clr = 1'b0; uart_rx_valid = 1'b0;
    step();

    // Full RX FIFO, new byte arrives in the same cycle as a pop.
    for (int i = 0; i < 4; i++) pulseRx(8'hC0 + 8'(i));
    uart_rx_data = 8'hC4; uart_rx_valid = 1'b1; host_rx_pop = 1'b1;
    step();
    uart_rx_valid = 1'b0; host_rx_pop = 1'b0;
    checkOutput("simul_overrun", rx_overrun, 0);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("simul_avail", host_rx_avail, 1);
      checkOutput("simul_order", host_rx_data, 8'hC0 + 8'(i));
      host_rx_pop = 1'b1;
      step();
      host_rx_pop = 1'b0;
    end
    checkOutput("simul_empty", host_rx_avail, 0);
    checkOutput("simul_overrun_end", rx_overrun, 0);

    // Randomized RX traffic against a queue model.
    lpc_rst = 1'b1; step(); step(); lpc_rst = 1'b0;
    begin
      logic prev_v, m_ov, v, p, c, edge_seen;
      prev_v = 1'b0; m_ov = 1'b0;
      rx_model.delete();
      for (int i = 0; i < 400; i++) begin
        v = 1'($urandom);
        p = ($urandom_range(0, 2) == 0);
        c = ($urandom_range(0, 7) == 0);
        d = 8'($urandom);
        uart_rx_valid = v; uart_rx_data = d; host_rx_pop = p; overrun_clr = c;
        edge_seen = v && !prev_v;
        prev_v = v;
        if (p && rx_model.size() > 0) void'(rx_model.pop_front());
        if (edge_seen && rx_model.size() == DEPTH) m_ov = 1'b1;
        else if (c) m_ov = 1'b0;
        if (edge_seen && rx_model.size() < DEPTH) rx_model.push_back(d);
        step();
        checkOutput("rand_rx_avail", host_rx_avail, rx_model.size() > 0);
        checkOutput("rand_rx_data", host_rx_data, (rx_model.size() > 0) ? rx_model[0] : 8'hFF);
        checkOutput("rand_rx_overrun", rx_overrun, m_ov);
      end
    end
    uart_rx_valid = 1'b0; host_rx_pop = 1'b0; overrun_clr = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
